ip_amba_apb_arbiter: RTL and testbench

IP_AMBA_APB_ARBITER -- requirements
Module: ip_amba_apb_arbiter

---
 rtl/ip_amba_apb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ip_amba_apb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_amba_apb_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// One transfer at a time: IDLE -> SETUP -> ACCESS -> RESP, or IDLE -> RESP on decode error.
module ip_amba_apb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PADDR_width   = 32,
  parameter int PWDATA_width  = 32,
  parameter int PRDATA_width  = 32,
  parameter int PSTRB_width   = PWDATA_width / 8,
  parameter int PSELx_width   = 2,
  parameter int SLV_ADDR_BITS = 12,
  parameter int TIMEOUT       = 16
) (
  input  logic                                    PCLK,
  input  logic                                    PRESETn,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ-1:0]                      req_write,
  input  logic [NUM_REQ-1:0][PADDR_width-1:0]     req_addr,
  input  logic [NUM_REQ-1:0][PWDATA_width-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0][PSTRB_width-1:0]     req_strb,
  input  logic [NUM_REQ-1:0][2:0]                 req_prot,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  output logic [PRDATA_width-1:0]                 rsp_rdata,
  output logic                                    rsp_err,
  output logic [PADDR_width-1:0]                  PADDR,
  output logic [2:0]                              PPROT,
  output logic [PSELx_width-1:0]                  PSELx,
  output logic                                    PENABLE,
  output logic                                    PWRITE,
  output logic [PWDATA_width-1:0]                 PWDATA,
  output logic [PSTRB_width-1:0]                  PSTRB,
  input  logic                                    PREADY,
  input  logic [PRDATA_width-1:0]                 PRDATA,
  input  logic                                    PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                    write;
    logic [PADDR_width-1:0]  addr;
    logic [PWDATA_width-1:0] wdata;
    logic [PSTRB_width-1:0]  strb;
    logic [2:0]              prot;
  } apb_req_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                 state_q, state_nxt;
  logic [IDX_W-1:0]       last_grant_q, owner_q, win;
  logic                   win_found;
  apb_req_t               win_req;
  logic [PADDR_width-1:0] slv_idx;
  logic                   dec_ok;
  logic [CNT_W-1:0]       acc_cnt_q;
  logic                   timeout_hit;

  // Search starts one past the last winner, so every requester waits at most NUM_REQ-1 grants.
  always_comb begin
    win       = last_grant_q;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid[IDX_W'((int'(last_grant_q) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win       = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    win_req.write = req_write[win];
    win_req.addr  = req_addr[win];
    win_req.wdata = req_wdata[win];
    win_req.strb  = req_strb[win];
    win_req.prot  = req_prot[win];
    slv_idx       = win_req.addr >> SLV_ADDR_BITS;
    dec_ok        = (slv_idx < PADDR_width'(PSELx_width));
  end

  assign timeout_hit = (acc_cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:   if (win_found) state_nxt = dec_ok ? S_SETUP : S_RESP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (PREADY || timeout_hit) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; PREADY wins over a timeout landing on the same cycle.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      acc_cnt_q    <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      PADDR        <= '0;
      PPROT        <= '0;
      PSELx        <= '0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PWDATA       <= '0;
      PSTRB        <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (win_found) begin
            req_ready    <= NUM_REQ'(1) << win;
            owner_q      <= win;
            last_grant_q <= win;
            if (dec_ok) begin
              PSELx   <= PSELx_width'(1) << slv_idx;
              PENABLE <= 1'b0;
              PADDR   <= win_req.addr;
              PPROT   <= win_req.prot;
              PWRITE  <= win_req.write;
              PWDATA  <= win_req.write ? win_req.wdata : '0;
              PSTRB   <= win_req.write ? win_req.strb  : '0;
            end else begin
              rsp_valid <= NUM_REQ'(1) << win;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          PENABLE   <= 1'b1;
          acc_cnt_q <= CNT_W'(1);
        end
        S_ACCESS: begin
          if (PREADY || timeout_hit) begin
            rsp_valid <= NUM_REQ'(1) << owner_q;
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
            rsp_err   <= PREADY ? PSLVERR : 1'b1;
            PSELx     <= '0;
            PENABLE   <= 1'b0;
            acc_cnt_q <= '0;
          end else begin
            acc_cnt_q <= acc_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_amba_apb_arbiter.sv
// Scoreboard bench: stimulus predicts grants/responses, a slave model plays APB, a monitor checks rsp.
module tb_ip_amba_apb_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_write = '0, rsp_valid;
  logic [N-1:0][31:0] req_addr = '0, req_wdata = '0;
  logic [N-1:0][3:0]  req_strb = '0;
  logic [N-1:0][2:0]  req_prot = '0;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic rsp_err, PENABLE, PWRITE;
  logic [2:0] PPROT;
  logic [1:0] PSELx;
  logic [3:0] PSTRB;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0] PRDATA = '0;

  ip_amba_apb_arbiter dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct { int owner; logic [31:0] rdata; logic err; int cyc; } exp_t;
  typedef struct {
    logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;
    logic [1:0] sel; int w; logic [31:0] rdata; logic err;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    r_w[N];
  logic [31:0] r_rd[N];
  logic  r_er[N];
  int    model_last = N - 1;
  int    total = 0, bad = 0;
  bit    g_flag;
  int    g_idx;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=expired required=event", nm);
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int w,
                         input logic [31:0] rd, input logic er);
    req_addr[i] = addr; req_write[i] = wr; req_wdata[i] = wd; req_strb[i] = st; req_prot[i] = pr;
    r_w[i] = w; r_rd[i] = rd; r_er[i] = er;
    req_valid[i] = 1'b1;
  endtask

  task automatic rand_req(input int i);
    int s, r, w;
    logic [31:0] addr;
    s = $urandom_range(0, 9);
    if (s < 4)       addr = {20'h0, 12'($urandom_range(0, 4095))};
    else if (s < 8)  addr = 32'h1000 | 32'($urandom_range(0, 4095));
    else if (s == 8) addr = 32'h2000 | 32'($urandom_range(0, 4095));
    else             addr = $urandom | 32'h1000_0000;
    r = $urandom_range(0, 19);
    if (r < 14)      w = $urandom_range(0, 3);
    else if (r < 16) w = TMO - 1;
    else if (r < 18) w = TMO;
    else             w = $urandom_range(TMO + 1, TMO + 6);
    set_req(i, addr, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), w, $urandom,
            ($urandom_range(0, 3) == 0));
  endtask

  // Reference: grant = first pending requester after the previous winner; response from the slave plan.
  task automatic handle_grant();
    int e, a;
    exp_t x;
    plan_t p;
    logic [31:0] slot;
    logic [N-1:0] ev;
    e = -1;
    for (int k = 1; k <= N; k++) begin
      if (e < 0 && req_valid[(model_last + k) % N]) e = (model_last + k) % N;
    end
    ev = (e < 0) ? '0 : N'(1 << e);
    chk("grant", 128'(req_ready), 128'(ev));
    if (e < 0) return;
    slot = req_addr[e] >> 12;
    x.owner = e;
    if (slot < 2) begin
      p.addr = req_addr[e]; p.wr = req_write[e]; p.prot = req_prot[e];
      p.wdata = p.wr ? req_wdata[e] : 32'h0;
      p.strb  = p.wr ? req_strb[e] : 4'h0;
      p.sel = 2'(1 << slot); p.w = r_w[e]; p.rdata = r_rd[e]; p.err = r_er[e];
      plan_q.push_back(p);
      a = (p.w + 1 > TMO) ? TMO : p.w + 1;
      x.cyc = cyc + a + 1;
      if (p.w >= TMO) begin x.err = 1'b1; x.rdata = '0; end
      else begin x.err = p.err; x.rdata = p.wr ? 32'h0 : p.rdata; end
    end else begin
      x.err = 1'b1; x.rdata = '0; x.cyc = cyc;
    end
    exp_q.push_back(x);
    model_last = e;
    req_valid[e] = 1'b0;
    g_flag = 1'b1;
    g_idx = e;
  endtask

  task automatic step(input bit gen);
    @(negedge PCLK);
    g_flag = 1'b0;
    if (req_ready != '0) handle_grant();
    if (gen)
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) rand_req(i);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || req_valid != '0) && n < 3000) begin
      step(0);
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
    repeat (3) step(0);
  endtask

  // APB slave model: plays each plan, randomizes PRDATA/PSLVERR whenever PREADY is low.
  initial begin
    plan_t cur;
    bit active;
    int acnt, lim;
    active = 1'b0; acnt = 0;
    forever begin
      @(negedge PCLK);
      #1;
      if (!PRESETn) begin
        active = 1'b0; PREADY = 1'b0;
      end else if (PSELx != '0 && !PENABLE) begin
        if (plan_q.size() == 0) fail_now("unexpected_setup");
        else begin
          cur = plan_q.pop_front();
          chk("setup", {PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSELx},
                       {cur.addr, cur.wr, cur.wdata, cur.strb, cur.prot, cur.sel});
          active = 1'b1; acnt = 0;
        end
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      end else if (PSELx != '0 && PENABLE && active) begin
        acnt++;
        chk("access_hold", {PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSELx},
                           {cur.addr, cur.wr, cur.wdata, cur.strb, cur.prot, cur.sel});
        PREADY  = (acnt == cur.w + 1);
        PRDATA  = PREADY ? cur.rdata : $urandom;
        PSLVERR = PREADY ? cur.err : 1'($urandom);
      end else begin
        if (active) begin
          lim = (cur.w + 1 > TMO) ? TMO : cur.w + 1;
          chk("access_cycles", 128'(acnt), 128'(lim));
          chk("apb_idle", {PSELx, PENABLE}, 3'b000);
          active = 1'b0;
        end
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t x;
    forever begin
      @(negedge PCLK);
      #2;
      if (PRESETn && rsp_valid != '0) begin
        if (exp_q.size() == 0) chk("rsp_spurious", 128'(rsp_valid), 128'(0));
        else begin
          x = exp_q.pop_front();
          chk("rsp", {rsp_valid, rsp_rdata, rsp_err, 32'(cyc)},
                     {N'(1 << x.owner), x.rdata, x.err, 32'(x.cyc)});
        end
      end
    end
  end

  initial begin
    int order[5];
    int want[5];
    int n, got;
    want = '{0, 1, 2, 3, 0};
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", {PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, rsp_valid, req_ready,
                          rsp_rdata, rsp_err}, '0);
    PRESETn = 1'b1;
    set_req(0, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'h0, 0, 32'hA5A5_0001, 1'b0);
    step(0);
    chk("first_grant_latency", 128'(req_ready), 128'(4'b0001));
    drain();
    set_req(2, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'b0101, 3'h2, 3, 32'h1234_5678, 1'b0);
    drain();
    set_req(1, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 3'h0, 0, 32'h5555_AAAA, 1'b0);
    drain();
    set_req(3, 32'h0000_1100, 1'b0, 32'h0, 4'h0, 3'h1, 40, 32'h7777_0000, 1'b0);
    drain();
    set_req(0, 32'h0000_0ffc, 1'b0, 32'h0, 4'h0, 3'h0, TMO - 1, 32'hC0DE_0015, 1'b0);
    drain();
    set_req(1, 32'h0000_0020, 1'b1, 32'h0BAD_F00D, 4'hF, 3'h4, 1, 32'hFFFF_FFFF, 1'b1);
    drain();

    repeat (500) step(1);
    drain();

    // Reset during ACCESS: transfer dies silently, arbitration restarts at requester 0.
    set_req(1, 32'h0000_1008, 1'b0, 32'h0, 4'h0, 3'h0, 40, 32'h1111_2222, 1'b0);
    n = 0;
    while (!(PENABLE && PSELx != '0) && n < 40) begin step(0); n++; end
    if (n >= 40) fail_now("access_wait");
    PRESETn = 1'b0;
    req_valid = '0;
    @(negedge PCLK);
    chk("reset_mid_outputs", {PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, rsp_valid, req_ready,
                              rsp_rdata, rsp_err}, '0);
    exp_q.delete();
    plan_q.delete();
    model_last = N - 1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'h0000_0100 * i, 1'b0, 0, 0, 0, 0, $urandom, 1'b0);
    got = 0; n = 0;
    while (got < 5 && n < 200) begin
      step(0);
      n++;
      if (g_flag) begin
        order[got] = g_idx;
        got++;
        if (got < 5) set_req(g_idx, 32'h0000_0040, 1'b0, 0, 0, 0, 0, $urandom, 1'b0);
      end
    end
    if (got < 5) fail_now("grant_order_wait");
    else for (int k = 0; k < 5; k++) chk("grant_order", 128'(order[k]), 128'(want[k]));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
